store_lane_packer: RTL and testbench

//  Store-side inverse of the immediate/load extender: narrows a 32-bit register value to

---
 rtl/store_lane_packer_pkg.sv | 22 ++
 rtl/store_lane_packer_lane_steer.sv | 42 ++++
 rtl/store_lane_packer.sv | 110 +++++++++++
 tb/tb_store_lane_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_lane_packer_pkg.sv
// Shared store-path definitions: access-size encodings and packer FSM state codes.
// The load extender imports the same size encodings so both sides agree on them.
package store_lane_packer_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Big-endian lanes are the little-endian lanes with the lane index reversed.
    function automatic logic [3:0] mirror_be(input logic [3:0] be);
        return {be[0], be[1], be[2], be[3]};
    endfunction

endpackage

// File: rtl/store_lane_packer_lane_steer.sv
// Combinational lane steering: replicates the store data across lanes, builds byte
// enables from size and low address bits, and flags misaligned or illegal requests.
module store_lane_packer_lane_steer
    import store_lane_packer_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    logic [3:0] be_le;

    always_comb begin
        wdata      = 32'h0;
        be_le      = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                wdata = {4{data[7:0]}};
                be_le = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata      = {2{data[15:0]}};
                be_le      = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                wdata      = data;
                be_le      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
        be = BIG_ENDIAN ? mirror_be(be_le) : be_le;
    end

endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer: accepts one store at a time, steers it onto data-memory byte
// lanes and runs the write strobe until ack, rejecting misaligned requests and bounding the wait.
module store_lane_packer
    import store_lane_packer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              done,
    output logic              misalign,
    output logic              timeout,
    output logic [1:0]        fsm_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the requester holds the request until then.
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      steer_wdata;
    logic [3:0]       steer_be;
    logic             steer_misaligned;

    store_lane_packer_lane_steer #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) lane_steer (
        .size      (req_size),
        .addr_lo   (req_addr[1:0]),
        .data      (req_wdata),
        .wdata     (steer_wdata),
        .be        (steer_be),
        .misaligned(steer_misaligned)
    );

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
            done      <= 1'b0;
            misalign  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (steer_misaligned) begin
                            misalign <= 1'b1;
                            state    <= ST_ERR;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= steer_wdata;
                            mem_be    <= steer_be;
                            wait_cnt  <= '0;
                            state     <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // Ack takes priority over the final timeout cycle.
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        // The timeout pulse also occupies RESP so no new pulse can abut it.
                        mem_we  <= 1'b0;
                        timeout <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP, ST_ERR: begin
                    done      <= 1'b0;
                    misalign  <= 1'b0;
                    timeout   <= 1'b0;
                    wait_cnt  <= '0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed bench for store_lane_packer: little- and big-endian instances share stimulus;
// expected values are hand-computed constants.
module tb_store_lane_packer;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        mem_ack = 1'b0;

    logic        req_ready, mem_we, done, misalign, timeout;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [1:0]  fsm_state;

    logic        req_ready_b, mem_we_b, done_b, misalign_b, timeout_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_be_b;
    logic [1:0]  fsm_state_b;

    int n_cmp = 0;
    int n_mis = 0;
    logic prev_pulse = 1'b0;

    always #5 clk = ~clk;

    store_lane_packer #(.ADDR_W(32), .TIMEOUT(TMO), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .done(done), .misalign(misalign), .timeout(timeout),
        .fsm_state(fsm_state)
    );

    store_lane_packer #(.ADDR_W(32), .TIMEOUT(TMO), .BIG_ENDIAN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_be(mem_be_b),
        .mem_ack(mem_ack), .done(done_b), .misalign(misalign_b), .timeout(timeout_b),
        .fsm_state(fsm_state_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag, input logic d, input logic m, input logic t);
        chk(tag, {29'h0, done, misalign, timeout}, {29'h0, d, m, t});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_size  = s;
    endtask

    // Pulses must be one-hot and never high on two consecutive cycles.
    always @(negedge clk) begin
        if (!rst && (done || misalign || timeout)) begin
            chk("pulse_excl", {30'h0, prev_pulse, 1'b0} | 32'(done + misalign + timeout),
                32'h1);
        end
        prev_pulse <= !rst && (done || misalign || timeout);
    end

    initial begin
        int done_at[$];
        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'h0, mem_be}, 32'h0);
        chk_pulses("rst_pulses", 1'b0, 1'b0, 1'b0);
        chk("rst_state", {30'h0, fsm_state}, 32'h0);
        chk("rst_be_b", {28'h0, mem_be_b}, 32'h0);

        // SB 0x1003, ack after two WRITE cycles
        drive(32'h0000_1003, 32'hDEAD_BEEF, 2'b00);
        step();
        req_valid = 1'b0;
        chk("sb_we", {31'h0, mem_we}, 32'h1);
        chk("sb_ready", {31'h0, req_ready}, 32'h0);
        chk("sb_addr", mem_addr, 32'h0000_1000);
        chk("sb_be", {28'h0, mem_be}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hEFEF_EFEF);
        chk("sb_be_big", {28'h0, mem_be_b}, 32'h1);
        step();
        chk("sb_we_hold", {31'h0, mem_we}, 32'h1);
        chk_pulses("sb_wait", 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk_pulses("sb_done", 1'b1, 1'b0, 1'b0);
        chk("sb_we_drop", {31'h0, mem_we}, 32'h0);
        step();
        chk_pulses("sb_done_end", 1'b0, 1'b0, 1'b0);
        chk("sb_ready_back", {31'h0, req_ready}, 32'h1);

        // SH 0x2002 with ack already high in IDLE (ignored) and in first WRITE cycle
        drive(32'h0000_2002, 32'h1234_5678, 2'b01);
        mem_ack = 1'b1;
        step();
        req_valid = 1'b0;
        chk("sh_we", {31'h0, mem_we}, 32'h1);
        chk("sh_be", {28'h0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'h5678_5678);
        chk("sh_addr", mem_addr, 32'h0000_2000);
        step();
        mem_ack = 1'b0;
        chk_pulses("sh_done", 1'b1, 1'b0, 1'b0);
        step();

        // SH 0x2001 misaligned
        drive(32'h0000_2001, 32'h1234_5678, 2'b01);
        step();
        req_valid = 1'b0;
        chk_pulses("sh_mis", 1'b0, 1'b1, 1'b0);
        chk("sh_mis_we", {31'h0, mem_we}, 32'h0);
        chk("sh_mis_ready", {31'h0, req_ready}, 32'h0);
        step();
        chk_pulses("sh_mis_end", 1'b0, 1'b0, 1'b0);
        chk("sh_mis_ready2", {31'h0, req_ready}, 32'h1);

        // SW 0x3000
        drive(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
        step();
        req_valid = 1'b0;
        chk("sw_be", {28'h0, mem_be}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("sw_addr", mem_addr, 32'h0000_3000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk_pulses("sw_done", 1'b1, 1'b0, 1'b0);
        step();

        // Illegal size and misaligned word; memory outputs keep the last write
        drive(32'h0000_3000, 32'h5555_AAAA, 2'b11);
        step();
        req_valid = 1'b0;
        chk_pulses("ill_mis", 1'b0, 1'b1, 1'b0);
        chk("ill_we", {31'h0, mem_we}, 32'h0);
        step();
        drive(32'h0000_3002, 32'h5555_AAAA, 2'b10);
        step();
        req_valid = 1'b0;
        chk_pulses("swmis_mis", 1'b0, 1'b1, 1'b0);
        chk("swmis_we", {31'h0, mem_we}, 32'h0);
        chk("swmis_wdata_kept", mem_wdata, 32'hCAFE_F00D);
        step();
        chk("swmis_we2", {31'h0, mem_we}, 32'h0);

        // No ack: timeout after TMO WRITE cycles
        drive(32'h0000_4000, 32'h1122_3344, 2'b10);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            chk("tmo_we_hold", {31'h0, mem_we}, 32'h1);
            chk_pulses("tmo_wait", 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_pulses("tmo_pulse", 1'b0, 1'b0, 1'b1);
        chk("tmo_we_drop", {31'h0, mem_we}, 32'h0);
        chk("tmo_ready_low", {31'h0, req_ready}, 32'h0);
        step();
        chk_pulses("tmo_end", 1'b0, 1'b0, 1'b0);
        chk("tmo_ready_back", {31'h0, req_ready}, 32'h1);

        // Ack on the last allowed WRITE cycle wins over timeout
        drive(32'h0000_4004, 32'h1122_3344, 2'b10);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step();
        chk("tmo_edge_we", {31'h0, mem_we}, 32'h1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk_pulses("tmo_edge_done", 1'b1, 1'b0, 1'b0);
        step();

        // Reset one cycle into WRITE drops the write
        drive(32'h0000_5000, 32'h0000_0077, 2'b00);
        step();
        req_valid = 1'b0;
        chk("rstw_we", {31'h0, mem_we}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_we_drop", {31'h0, mem_we}, 32'h0);
        chk("rstw_ready", {31'h0, req_ready}, 32'h1);
        chk_pulses("rstw_pulses", 1'b0, 1'b0, 1'b0);
        step();
        chk_pulses("rstw_quiet", 1'b0, 1'b0, 1'b0);
        drive(32'h0000_6000, 32'h89AB_CDEF, 2'b10);
        step();
        req_valid = 1'b0;
        mem_ack = 1'b1;
        chk("rstw_new_addr", mem_addr, 32'h0000_6000);
        step();
        mem_ack = 1'b0;
        chk_pulses("rstw_new_done", 1'b1, 1'b0, 1'b0);
        step();

        // Big-endian lanes
        drive(32'h0000_0000, 32'h0000_00AB, 2'b00);
        step();
        req_valid = 1'b0;
        chk("be_sb_be", {28'h0, mem_be_b}, 32'h8);
        chk("be_sb_wdata", mem_wdata_b, 32'hABAB_ABAB);
        chk("le_sb_be", {28'h0, mem_be}, 32'h1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("be_sb_done", {31'h0, done_b}, 32'h1);
        step();
        drive(32'h0000_0002, 32'h0000_BEEF, 2'b01);
        step();
        req_valid = 1'b0;
        chk("be_sh_be", {28'h0, mem_be_b}, 32'h3);
        chk("be_sh_wdata", mem_wdata_b, 32'hBEEF_BEEF);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();

        // Back-to-back: held request and ack give one store every 3 cycles
        drive(32'h0000_7000, 32'h0BAD_F00D, 2'b10);
        mem_ack = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (done) done_at.push_back(i);
        end
        req_valid = 1'b0;
        mem_ack = 1'b0;
        chk("b2b_count", 32'(done_at.size()), 32'd3);
        if (done_at.size() == 3) begin
            chk("b2b_first", 32'(done_at[0]), 32'd2);
            chk("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'd3);
            chk("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'd3);
        end
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed time limit reached expected summary");
        $fatal(1, "watchdog");
    end

endmodule
